// File: rtl/key_scheduler_if.sv
// Handshake and S-RAM port bundle for the RC4 key scheduler.
// The master side drives start/key/read data; the slave side is the scheduler.
interface key_scheduler_if;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output secret_key,
        output q,
        input  address,
        input  data,
        input  wren,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  secret_key,
        input  q,
        output address,
        output data,
        output wren,
        output busy,
        output done
    );
endinterface

// File: rtl/key_scheduler.sv
// RC4 key-scheduling swap pass over an external 256-byte S-RAM.
// The RAM has one cycle of read latency; each iteration takes six states.
module key_scheduler (
    input logic             clk,
    input logic             rst,
    key_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        WT_I = 3'd2,
        RD_J = 3'd3,
        WT_J = 3'd4,
        WR_I = 3'd5,
        WR_J = 3'd6,
        DONE = 3'd7
    } state_t;

    state_t      state_r;
    logic [7:0]  i_r;
    logic [7:0]  j_r;
    logic [7:0]  si_r;
    logic [7:0]  sj_r;
    logic [1:0]  kidx_r;
    logic [23:0] key_r;

    logic [7:0]  address_r;
    logic [7:0]  data_r;
    logic        wren_r;
    logic        busy_r;
    logic        done_r;

    logic [7:0]  next_j_s;

    // Key byte selected by the i mod 3 counter; K[0] is the top byte.
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = key[23:16];
            2'd1:    b = key[15:8];
            default: b = key[7:0];
        endcase
        return b;
    endfunction

    // New j from the S[i] read data; it feeds registers only, never an output directly.
    always_comb begin
        next_j_s = j_r + bus.q + key_byte(key_r, kidx_r);
    end

    // Control FSM; outputs are loaded on each transition so they are valid for the whole state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            i_r       <= 8'd0;
            j_r       <= 8'd0;
            si_r      <= 8'd0;
            sj_r      <= 8'd0;
            kidx_r    <= 2'd0;
            key_r     <= 24'd0;
            address_r <= 8'd0;
            data_r    <= 8'd0;
            wren_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        key_r     <= bus.secret_key;
                        i_r       <= 8'd0;
                        j_r       <= 8'd0;
                        kidx_r    <= 2'd0;
                        address_r <= 8'd0;
                        wren_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        state_r   <= RD_I;
                    end else begin
                        state_r   <= state_r;
                    end
                end
                RD_I: begin
                    address_r <= i_r;
                    state_r   <= WT_I;
                end
                WT_I: begin
                    si_r      <= bus.q;
                    j_r       <= next_j_s;
                    address_r <= next_j_s;
                    state_r   <= RD_J;
                end
                RD_J: begin
                    address_r <= j_r;
                    state_r   <= WT_J;
                end
                WT_J: begin
                    sj_r      <= bus.q;
                    address_r <= i_r;
                    data_r    <= bus.q;
                    wren_r    <= 1'b1;
                    state_r   <= WR_I;
                end
                WR_I: begin
                    address_r <= j_r;
                    data_r    <= si_r;
                    wren_r    <= 1'b1;
                    state_r   <= WR_J;
                end
                WR_J: begin
                    wren_r <= 1'b0;
                    if (i_r == 8'd255) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        i_r       <= i_r + 8'd1;
                        kidx_r    <= (kidx_r == 2'd2) ? 2'd0 : kidx_r + 2'd1;
                        address_r <= i_r + 8'd1;
                        state_r   <= RD_I;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    address_r <= 8'd0;
                    data_r    <= 8'd0;
                    wren_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address = address_r;
    assign bus.data    = data_r;
    assign bus.wren    = wren_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_key_scheduler.sv
// Scoreboard bench for key_scheduler: expected S-RAM writes are queued at start,
// a negedge monitor pops and compares every write the scheduler issues.
module tb_key_scheduler;

    logic clk;
    logic rst;
    logic init_req;
    int   checks;
    int   errors;

    logic [7:0]  mem [256];
    logic [7:0]  sm  [256];
    logic [15:0] exp_q [$];

    key_scheduler_if bus ();

    key_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // S-RAM model: synchronous write, registered read, bulk identity load on request.
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= k[7:0];
        end else if (bus.wren) begin
            mem[bus.address] <= bus.data;
        end
        bus.q <= mem[bus.address];
    end

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (!rst && bus.wren) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_extra got addr=%02h data=%02h expected no write", bus.address, bus.data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({bus.address, bus.data} !== e)
                begin
                    errors++;
                    $display("FAIL write got addr=%02h data=%02h expected addr=%02h data=%02h",
                             bus.address, bus.data, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk8({tag, "_address"}, bus.address, 8'h00);
        chk8({tag, "_data"},    bus.data,    8'h00);
        chk8({tag, "_wren"},    {7'd0, bus.wren}, 8'h00);
        chk8({tag, "_busy"},    {7'd0, bus.busy}, 8'h00);
        chk8({tag, "_done"},    {7'd0, bus.done}, 8'h00);
    endtask

    task automatic init_s();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int k = 0; k < 256; k++) sm[k] = k[7:0];
    endtask

    // Reference software KSA on sm; queues the two writes of each iteration.
    task automatic ksa_push(input logic [23:0] key);
        logic [7:0] kb [3];
        logic [7:0] j;
        logic [7:0] t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j = j + sm[i] + kb[i % 3];
            exp_q.push_back({i[7:0], sm[j]});
            exp_q.push_back({j, sm[i]});
            t     = sm[i];
            sm[i] = sm[j];
            sm[j] = t;
        end
    endtask

    task automatic run_pass(input logic [23:0] key, input bit toggle, input bit hold,
                            input logic [7:0] exp_j0, input bit chk_s0);
        int cnt;
        bus.secret_key = key;
        bus.start      = 1'b1;
        step();
        cnt = 1;
        if (!hold) bus.start = 1'b0;
        chk8("pass_rdi_addr", bus.address, 8'h00);
        chk8("pass_busy", {7'd0, bus.busy}, 8'h01);
        while (!bus.done && cnt < 2000) begin
            step();
            cnt++;
            if (cnt == 2) bus.start = 1'b0;
            if (cnt == 3) chk8("pass_first_j", bus.address, exp_j0);
            if (chk_s0 && cnt == 7) chk8("pass_s0_kept", mem[0], 8'h00);
            if (toggle && cnt >= 10 && cnt <= 40) begin
                bus.start      = cnt[0];
                bus.secret_key = 24'hABCDEF;
            end
        end
        chki("pass_done_edges", cnt, 1537);
        chk8("pass_busy_end", {7'd0, bus.busy}, 8'h00);
        step();
        for (int k = 0; k < 256; k++)
            chk8($sformatf("final_s[%0d]", k), mem[k], sm[k]);
        chki("pass_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        init_req       = 1'b0;
        bus.start      = 1'b0;
        bus.secret_key = 24'h000000;
        #2 rst = 1'b1;
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        // First iterations with key 0x0A0B0C, then an asynchronous reset inside WR_I.
        init_s();
        exp_q.push_back({8'h00, 8'h0A});
        exp_q.push_back({8'h0A, 8'h00});
        exp_q.push_back({8'h01, 8'h16});
        exp_q.push_back({8'h16, 8'h01});
        bus.secret_key = 24'h0A0B0C;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        chk8("a_rdi_addr", bus.address, 8'h00);
        chk8("a_rdi_wren", {7'd0, bus.wren}, 8'h00);
        chk8("a_busy", {7'd0, bus.busy}, 8'h01);
        chk8("a_done", {7'd0, bus.done}, 8'h00);
        step(); chk8("a_wti_addr", bus.address, 8'h00);
        step(); chk8("a_rdj_addr", bus.address, 8'h0A);
        step(); chk8("a_wtj_addr", bus.address, 8'h0A);
        chk8("a_wtj_wren", {7'd0, bus.wren}, 8'h00);
        step(); chk8("a_wri_wren", {7'd0, bus.wren}, 8'h01);
        chk8("a_wri_addr", bus.address, 8'h00);
        chk8("a_wri_data", bus.data, 8'h0A);
        step(); chk8("a_wrj_addr", bus.address, 8'h0A);
        chk8("a_wrj_data", bus.data, 8'h00);
        step(); chk8("a_it2_rdi_addr", bus.address, 8'h01);
        step();
        step(); chk8("a_it2_rdj_addr", bus.address, 8'h16);
        for (int n = 0; n < 8; n++) step();
        chk8("a_it3_wri_wren", {7'd0, bus.wren}, 8'h01);
        chk8("a_it3_wri_data", bus.data, 8'h24);
        rst = 1'b1;
        #1 chk_all_zero("midpass_rst");
        chki("a_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        chk8("post_rst_idle_busy", {7'd0, bus.busy}, 8'h00);
        chk8("post_rst_idle_done", {7'd0, bus.done}, 8'h00);

        // Full pass, key 0: first iteration is the i==j case.
        init_s();
        ksa_push(24'h000000);
        run_pass(24'h000000, 1'b0, 1'b0, 8'h00, 1'b1);

        // Start toggling and key changes while busy must not disturb the pass.
        init_s();
        ksa_push(24'h123456);
        run_pass(24'h123456, 1'b1, 1'b0, 8'h12, 1'b0);
        chk8("done_held", {7'd0, bus.done}, 8'h01);

        // Start held in DONE restarts from i=j=0; key 0xFFFFFF forces j to wrap.
        init_s();
        ksa_push(24'hFFFFFF);
        run_pass(24'hFFFFFF, 1'b0, 1'b1, 8'hFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
